mem_bus_responder: RTL

//  Memory-side responder for the multiplexed SysBus (ALE/nME/nOE/nWE/ENB) driven by the CPU control unit.

---
 rtl/mem_bus_responder_if.sv | 18 +
 rtl/mem_bus_responder.sv | 103 ++++++++++
 2 files changed

// File: rtl/mem_bus_responder_if.sv
// SysBus pin group between the CPU-side master and the memory-side responder.
interface mem_bus_responder_if;
  logic [15:0] SysBusIn;
  logic [15:0] SysBusOut;
  logic        SysBusOe;
  logic        ALE;
  logic        nME;
  logic        nOE;
  logic        nWE;
  logic        ENB;
  logic        Ready;
  logic        ProtErr;

  modport slave  (input  SysBusIn, ALE, nME, nOE, nWE, ENB,
                  output SysBusOut, SysBusOe, Ready, ProtErr);
  modport master (output SysBusIn, ALE, nME, nOE, nWE, ENB,
                  input  SysBusOut, SysBusOe, Ready, ProtErr);
endinterface

// File: rtl/mem_bus_responder.sv
// Memory-side SysBus responder: latches the address phase, then services one
// read or write against a 2**AW x 16 word RAM after WAIT_STATES extra cycles.
module mem_bus_responder #(
  parameter int          AW          = 6,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic Clock,
  input  logic Reset,
  mem_bus_responder_if.slave bus
);
  localparam int         DEPTH = 1 << AW;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, DRIVE, WDONE} state_t;

  state_t        state;
  logic [AW-1:0] addr_reg;
  logic [3:0]    wait_cnt;
  logic          is_wr;
  logic [15:0]   mem [DEPTH];

  logic hit, abort_sel, abort_ale, ram_we;

  assign hit       = (bus.SysBusIn[15:AW] == BASE_ADDR[15:AW]);
  assign abort_sel = bus.nME;
  assign abort_ale = bus.ALE & ~bus.nME;
  // Aborts win over the final WAIT edge, so a cancelled write never lands.
  assign ram_we    = ~Reset && (state == WAIT) && is_wr && (wait_cnt == 4'd0) &&
                     ~abort_sel && ~abort_ale;

  always_ff @(posedge Clock) begin
    if (ram_we)
      mem[addr_reg] <= bus.ENB ? {mem[addr_reg][15:8], bus.SysBusIn[7:0]} : bus.SysBusIn;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= IDLE;
      addr_reg      <= '0;
      wait_cnt      <= '0;
      is_wr         <= 1'b0;
      bus.SysBusOut <= '0;
      bus.SysBusOe  <= 1'b0;
      bus.Ready     <= 1'b0;
      bus.ProtErr   <= 1'b0;
    end else if (state != IDLE && (abort_sel || abort_ale)) begin
      bus.SysBusOe <= 1'b0;
      bus.Ready    <= 1'b0;
      if (abort_ale) begin
        addr_reg <= bus.SysBusIn[AW-1:0];
        state    <= hit ? ADDR : IDLE;
      end else begin
        state <= IDLE;
      end
    end else begin
      case (state)
        IDLE: if (abort_ale) begin
          addr_reg <= bus.SysBusIn[AW-1:0];
          state    <= hit ? ADDR : IDLE;
        end
        ADDR: begin
          if (!bus.nOE && bus.nWE) begin
            is_wr    <= 1'b0;
            wait_cnt <= WS;
            state    <= WAIT;
          end else if (!bus.nWE && bus.nOE) begin
            is_wr    <= 1'b1;
            wait_cnt <= WS;
            state    <= WAIT;
          end else if (!bus.nOE && !bus.nWE) begin
            bus.ProtErr <= 1'b1;
            state       <= IDLE;
          end
        end
        WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            bus.Ready <= 1'b1;
            if (is_wr) begin
              state <= WDONE;
            end else begin
              bus.SysBusOut <= mem[addr_reg];
              bus.SysBusOe  <= 1'b1;
              state         <= DRIVE;
            end
          end
        end
        DRIVE: if (bus.nOE) begin
          bus.SysBusOe <= 1'b0;
          bus.Ready    <= 1'b0;
          state        <= IDLE;
        end
        WDONE: begin
          bus.Ready <= 1'b0;
          if (bus.nWE) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
